percept_core: RTL and testbench

Single serial-I/O perceptron multiply-accumulate node.
- Operands arrive on a 1-bit serial input: first a weight, then an input value, both MSB-first.
- Each mul_and_acc cycle adds the product weight×input into an accumulator.
- The accumulator is read out MSB-first on a 1-bit serial output.
- Intended as a tile of a bit-serial neural-net array with minimal routing.

---
 rtl/percept_core.sv | 106 ++++++++++
 tb/tb_percept_core.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/percept_core.sv
// percept_core
// ------------
// Bit-serial perceptron multiply-accumulate node. Operands are shifted in
// MSB-first on a single wire (weight first, then input). Each MAC cycle adds
// the signed product weight*input into an accumulator. The accumulator is
// read back MSB-first on a single registered output wire, and the readout
// destroys the value.
//
// Optional feature: define PERCEPT_SAT_EN to make the MAC saturate instead of
// wrap. Without it, accumulation wraps modulo 2^ACC_WIDTH and no clamp logic
// exists.
//
// Parameters:
//   WIDTH       operand width (weight and input), signed two's complement
//   ACC_WIDTH   accumulator width, must be >= 2*WIDTH
//
// Ports:
//   clk          system clock, all state updates on the rising edge
//   nRst         synchronous reset, active HIGH despite the name
//   shift_in     shift data_in into the operand chain
//   shift_out    shift one accumulator bit out to data_out
//   mul_and_acc  accumulator += weight*input
//   data_in      serial operand bit, MSB-first, weight first
//   data_out     registered serial accumulator bit, MSB-first
//
// When several controls are high together, only the highest-priority one acts:
// nRst, then shift_in, then mul_and_acc, then shift_out.

module percept_core #(
  parameter int WIDTH     = 32,
  parameter int ACC_WIDTH = 64
) (
  input  logic clk,
  input  logic nRst,
  input  logic shift_in,
  input  logic shift_out,
  input  logic mul_and_acc,
  input  logic data_in,
  output logic data_out
);

  localparam int CW = 2 * WIDTH;

  logic [CW-1:0]               r_opchain;
  logic [ACC_WIDTH-1:0]        r_acc;
  logic                        r_data_out;

  logic signed [WIDTH-1:0]     w_weight;
  logic signed [WIDTH-1:0]     w_input;
  logic signed [CW-1:0]        w_weight_ext;
  logic signed [CW-1:0]        w_input_ext;
  logic signed [CW-1:0]        w_product;
  logic signed [ACC_WIDTH-1:0] w_product_ext;
  logic [ACC_WIDTH-1:0]        w_sum;
  logic [ACC_WIDTH-1:0]        w_acc_next;

  // The oldest bits sit at the top of the chain, so after a full load the
  // weight occupies the upper half and the input the lower half.
  assign w_weight = r_opchain[CW-1:WIDTH];
  assign w_input  = r_opchain[WIDTH-1:0];

  // Both operands are widened to the full product width before multiplying
  // so the product is exact; the product is then sign-extended to the
  // accumulator width.
  assign w_weight_ext  = CW'(w_weight);
  assign w_input_ext   = CW'(w_input);
  assign w_product     = w_weight_ext * w_input_ext;
  assign w_product_ext = ACC_WIDTH'(w_product);
  assign w_sum         = r_acc + w_product_ext;

`ifdef PERCEPT_SAT_EN
  // Saturating add: overflow is only possible when both addends share a sign
  // and the wrapped sum comes out with the opposite sign.
  always_comb begin
    w_acc_next = w_sum;
    if (!r_acc[ACC_WIDTH-1] && !w_product_ext[ACC_WIDTH-1] && w_sum[ACC_WIDTH-1]) begin
      w_acc_next = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    end else if (r_acc[ACC_WIDTH-1] && w_product_ext[ACC_WIDTH-1] && !w_sum[ACC_WIDTH-1]) begin
      w_acc_next = {1'b1, {(ACC_WIDTH-1){1'b0}}};
    end
  end
`else
  // Plain wrap-around accumulation.
  assign w_acc_next = w_sum;
`endif

  // Single state process so the priority chain is explicit: exactly one
  // operation happens per cycle and everything else holds its value.
  always_ff @(posedge clk) begin
    if (nRst) begin
      r_opchain  <= '0;
      r_acc      <= '0;
      r_data_out <= 1'b0;
    end else if (shift_in) begin
      r_opchain <= {r_opchain[CW-2:0], data_in};
    end else if (mul_and_acc) begin
      r_acc <= w_acc_next;
    end else if (shift_out) begin
      r_data_out <= r_acc[ACC_WIDTH-1];
      r_acc      <= {r_acc[ACC_WIDTH-2:0], 1'b0};
    end
  end

  assign data_out = r_data_out;

endmodule

// File: tb/tb_percept_core.sv
// tb_percept_core
// ---------------
// Testbench for percept_core with the default 32-bit operands and 64-bit
// accumulator. A behavioural model tracks the operand chain as a number, the
// accumulator as a 64-bit signed integer and the last bit read out.
// Directed scenarios are followed by a randomized control sequence.

module tb_percept_core;

  logic clk;
  logic nRst;
  logic shift_in;
  logic shift_out;
  logic mul_and_acc;
  logic data_in;
  logic data_out;

  int total;
  int bad;

  // Behavioural model state
  logic [63:0] mChain;
  longint      mAcc;
  logic        mOut;

  percept_core #(
    .WIDTH(32),
    .ACC_WIDTH(64)
  ) dut (
    .clk(clk),
    .nRst(nRst),
    .shift_in(shift_in),
    .shift_out(shift_out),
    .mul_and_acc(mul_and_acc),
    .data_in(data_in),
    .data_out(data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // MAC as seen from the arithmetic: signed product of the two halves of the
  // loaded operand pair, added to the accumulator.
  function automatic longint macModel(input longint acc, input logic [63:0] chain);
    int     w;
    int     x;
    longint p;
    longint s;
    w = int'(chain[63:32]);
    x = int'(chain[31:0]);
    p = longint'(w) * longint'(x);
    s = acc + p;
`ifdef PERCEPT_SAT_EN
    if (acc >= 0 && p >= 0 && s < 0) s = 64'sh7FFF_FFFF_FFFF_FFFF;
    else if (acc < 0 && p < 0 && s >= 0) s = 64'sh8000_0000_0000_0000;
`endif
    return s;
  endfunction

  // Drive one clock cycle of controls and advance the model by the same
  // operation, honouring the priority reset > shift_in > MAC > shift_out.
  task automatic applyStimulus(input logic rst, input logic si, input logic mac,
                               input logic so, input logic din);
    nRst        = rst;
    shift_in    = si;
    mul_and_acc = mac;
    shift_out   = so;
    data_in     = din;
    @(posedge clk);
    #1;
    if (rst) begin
      mChain = '0;
      mAcc   = 0;
      mOut   = 1'b0;
    end else if (si) begin
      mChain = mChain * 2 + 64'(din);
    end else if (mac) begin
      mAcc = macModel(mAcc, mChain);
    end else if (so) begin
      mOut = (mAcc < 0);
      mAcc = mAcc * 2;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic loadOperands(input logic [31:0] w, input logic [31:0] x);
    logic [63:0] bits;
    bits = {w, x};
    for (int i = 63; i >= 0; i--) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, bits[i]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Full 64-cycle readout; the first bit is visible one cycle after the
  // first shift_out edge.
  task automatic readAcc(input string tag, input logic [63:0] fixedExpect,
                         input logic useFixed);
    logic [63:0] got;
    logic [63:0] modelExpect;
    modelExpect = mAcc;
    got = '0;
    for (int i = 0; i < 64; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      got = {got[62:0], data_out};
      if (i == 0) checkOutput({tag, "_firstbit"}, 64'(data_out), 64'(modelExpect[63]));
    end
    checkOutput(tag, got, modelExpect);
    if (useFixed) checkOutput({tag, "_const"}, got, fixedExpect);
  endtask

  initial begin
    logic        heldOut;
    logic [31:0] rw;
    logic [31:0] rx;
    logic        rsi;
    logic        rmac;
    logic        rso;
    logic        rdin;
    int          r;

    total       = 0;
    bad         = 0;
    mChain      = '0;
    mAcc        = 0;
    mOut        = 1'b0;
    nRst        = 1'b0;
    shift_in    = 1'b0;
    shift_out   = 1'b0;
    mul_and_acc = 1'b0;
    data_in     = 1'b0;

    // Reset overrides every other control.
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    checkOutput("reset_dout", 64'(data_out), 64'd0);
    readAcc("reset_readout", 64'd0, 1'b1);

    // Basic MAC: 2000 * 1000 twice.
    loadOperands(32'd2000, 32'd1000);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    readAcc("basic_mac", 64'h0000_0000_003D_0900, 1'b1);

    // Destructive readout leaves zero behind.
    readAcc("destructive", 64'd0, 1'b1);

    // Signed product -3 * 7.
    loadOperands(32'hFFFF_FFFD, 32'd7);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    readAcc("signed_mac", 64'hFFFF_FFFF_FFFF_FFEB, 1'b1);

    // data_out ends on the LSB of -21 (a 1) and must hold while idle.
    heldOut = data_out;
    idle(5);
    checkOutput("idle_hold", 64'(data_out), 64'd1);
    checkOutput("idle_hold_model", 64'(data_out), 64'(heldOut));

    // Priority: shift_in beats MAC, then MAC beats shift_out.
    loadOperands(32'd5, 32'd3);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);          // acc = 15
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);          // chain shifts, no MAC
    heldOut = data_out;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);          // only MAC: 15 + 10*6
    checkOutput("prio_no_shiftout", 64'(data_out), 64'(heldOut));
    readAcc("priority", 64'd75, 1'b1);

    // Overflow: (-2^31)^2 accumulated twice.
    loadOperands(32'h8000_0000, 32'h8000_0000);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
`ifdef PERCEPT_SAT_EN
    readAcc("overflow_sat", 64'h7FFF_FFFF_FFFF_FFFF, 1'b1);
`else
    readAcc("overflow_wrap", 64'h8000_0000_0000_0000, 1'b1);
`endif

    // Negative saturation direction: large negative products, four times.
    loadOperands(32'h8000_0000, 32'h7FFF_FFFF);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    readAcc("neg_accum", 64'd0, 1'b0);

    // Random operand loads with random MAC counts.
    for (int k = 0; k < 6; k++) begin
      rw = $urandom;
      rx = $urandom;
      loadOperands(rw, rx);
      r = $urandom_range(1, 3);
      for (int i = 0; i < r; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      if ($urandom_range(0, 1) == 1) readAcc("rand_mac", 64'd0, 1'b0);
    end
    readAcc("rand_mac_final", 64'd0, 1'b0);

    // Random mixed controls, data_out checked every cycle.
    for (int k = 0; k < 300; k++) begin
      rsi  = ($urandom_range(0, 9) < 4);
      rmac = ($urandom_range(0, 9) < 3);
      rso  = ($urandom_range(0, 9) < 5);
      rdin = 1'($urandom_range(0, 1));
      applyStimulus(1'b0, rsi, rmac, rso, rdin);
      checkOutput("rand_ctrl_dout", 64'(data_out), 64'(mOut));
    end
    readAcc("rand_ctrl_final", 64'd0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
